// File: rtl/cpu_execute_divider_if.sv
// Request/response bundle between the execute stage and the iterative divider.
// The master side drives operands and control; the slave side is the divider.
interface cpu_execute_divider_if #(
    parameter int unsigned WIDTH = 32
);
    logic             i_flush;
    logic             i_request;
    logic [1:0]       i_op;
    logic [WIDTH-1:0] i_rs1;
    logic [WIDTH-1:0] i_rs2;
    logic             o_busy;
    logic             o_ready;
    logic [WIDTH-1:0] o_result;

    modport master (
        output i_flush,
        output i_request,
        output i_op,
        output i_rs1,
        output i_rs2,
        input  o_busy,
        input  o_ready,
        input  o_result
    );

    modport slave (
        input  i_flush,
        input  i_request,
        input  i_op,
        input  i_rs1,
        input  i_rs2,
        output o_busy,
        output o_ready,
        output o_result
    );
endinterface

// File: rtl/cpu_execute_divider.sv
// RV32M DIV/DIVU/REM/REMU unit, one restoring-division bit per clock.
// Optional CPU_DIV_EARLY_OUT_EN skips the iterations for zero divisors and |rs1| < |rs2|.
module cpu_execute_divider #(
    parameter int unsigned WIDTH = 32
) (
    input logic                  i_clock,
    input logic                  i_reset,
    cpu_execute_divider_if.slave bus
);
    localparam int unsigned      CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0]  CntLast = CntW'(WIDTH - 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StDivide = 2'd1;
    localparam logic [1:0] StFixup  = 2'd2;
    localparam logic [1:0] StDone   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             is_rem_q, is_rem_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             skip_q, skip_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             signed_op;
    logic             rs1_neg;
    logic             rs2_neg;
    logic [WIDTH-1:0] rs1_mag;
    logic [WIDTH-1:0] rs2_mag;
    logic             accept;
    logic [WIDTH:0]   rem_shift;
    logic             take;

    always_comb begin
        signed_op = ~bus.i_op[0];
        rs1_neg   = signed_op & bus.i_rs1[WIDTH-1];
        rs2_neg   = signed_op & bus.i_rs2[WIDTH-1];
        rs1_mag   = rs1_neg ? -bus.i_rs1 : bus.i_rs1;
        rs2_mag   = rs2_neg ? -bus.i_rs2 : bus.i_rs2;
        accept    = bus.i_request && !bus.i_flush &&
                    (state_q == StIdle || state_q == StDone);
        // The shifted partial remainder needs one extra bit; after a
        // conditional subtract it always fits back into WIDTH bits.
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        take      = rem_shift >= {1'b0, divisor_q};
    end

    always_comb begin
        state_d   = state_q;
        is_rem_d  = is_rem_q;
        divisor_d = divisor_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        count_d   = count_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        skip_d    = skip_q;
        result_d  = result_q;

        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (accept) begin
                    state_d   = StDivide;
                    is_rem_d  = bus.i_op[1];
                    divisor_d = rs2_mag;
                    quo_d     = rs1_mag;
                    rem_d     = '0;
                    count_d   = '0;
                    neg_quo_d = (rs1_neg ^ rs2_neg) && (bus.i_rs2 != '0);
                    neg_rem_d = rs1_neg;
                    skip_d    = 1'b0;
`ifdef CPU_DIV_EARLY_OUT_EN
                    // Answer is already known: pass straight through to fixup.
                    if (bus.i_rs2 == '0 || rs1_mag < rs2_mag) begin
                        skip_d = 1'b1;
                        quo_d  = (bus.i_rs2 == '0) ? '1 : '0;
                        rem_d  = rs1_mag;
                    end
`endif
                end
            end
            StDivide: begin
                if (skip_q) begin
                    skip_d  = 1'b0;
                    state_d = StFixup;
                end else begin
                    rem_d = take ? (rem_shift[WIDTH-1:0] - divisor_q) : rem_shift[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], take};
                    if (count_q == CntLast) begin
                        count_d = '0;
                        state_d = StFixup;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            StFixup: begin
                // Overflow and divide-by-zero fall out of the magnitude
                // arithmetic and the sign flags without extra cases.
                if (is_rem_q) begin
                    result_d = neg_rem_q ? -rem_q : rem_q;
                end else begin
                    result_d = neg_quo_q ? -quo_q : quo_q;
                end
                state_d = StDone;
            end
            default: state_d = StIdle;
        endcase

        if (bus.i_flush) begin
            state_d  = StIdle;
            result_d = result_q;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= StIdle;
            is_rem_q  <= 1'b0;
            divisor_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            count_q   <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            skip_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            is_rem_q  <= is_rem_d;
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            count_q   <= count_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            skip_q    <= skip_d;
            result_q  <= result_d;
        end
    end

    assign bus.o_busy   = (state_q == StDivide) || (state_q == StFixup);
    assign bus.o_ready  = (state_q == StDone);
    assign bus.o_result = result_q;
endmodule
